// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron input accumulator.
// Float32 width, zero constant and the accumulator state encoding.
package neuron_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    ADD,
    FLUSH
  } acc_state_t;

endpackage

// File: rtl/neuron_input_accumulator_if.sv
// Spike delivery, weight config and result handshake bundle
// between the NoC port, the accumulator and the potential adder.
interface neuron_input_accumulator_if #(
  parameter int SRC_W = 4
) ();

  logic             weight_wr_en;
  logic [SRC_W-1:0] weight_wr_addr;
  logic [31:0]      weight_wr_data;
  logic             spike_valid;
  logic [SRC_W-1:0] spike_src;
  logic             spike_ready;
  logic             time_step;
  logic [31:0]      input_weight;
  logic             weight_valid;
  logic             weight_ack;
  logic             overrun;
  logic             fp_exc;

  modport master (
    output weight_wr_en,
    output weight_wr_addr,
    output weight_wr_data,
    output spike_valid,
    output spike_src,
    input  spike_ready,
    output time_step,
    input  input_weight,
    input  weight_valid,
    output weight_ack,
    input  overrun,
    input  fp_exc
  );

  modport slave (
    input  weight_wr_en,
    input  weight_wr_addr,
    input  weight_wr_data,
    input  spike_valid,
    input  spike_src,
    output spike_ready,
    input  time_step,
    output input_weight,
    output weight_valid,
    input  weight_ack,
    output overrun,
    output fp_exc
  );

endinterface

// File: rtl/neuron_input_accumulator_fpadd.sv
// Combinational float32 add/subtract, round-to-nearest-even.
// Exception flags overflow to infinity or an Inf/NaN operand.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic [31:0] x, y, bs;
  logic        sx, sub, found, up;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_sh;
  logic [27:0] s;
  logic [24:0] mr;
  logic [9:0]  e;
  logic [4:0]  lz, sh;

  always_comb begin
    bs = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    if (a_operand[30:0] >= bs[30:0]) begin
      x = a_operand;
      y = bs;
    end else begin
      x = bs;
      y = a_operand;
    end
    sx  = x[31];
    sub = x[31] ^ y[31];
    ex  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx  = {|x[30:23], x[22:0], 3'b000};
    my  = {|y[30:23], y[22:0], 3'b000};
    d   = ex - ey;
    // Alignment keeps a sticky bit so rounding sees every shifted-out one
    if (d > 8'd26) begin
      my_sh = {26'd0, |my};
    end else begin
      my_sh    = my >> d;
      my_sh[0] = my_sh[0] | (|(my & ~({27{1'b1}} << d)));
    end
    s = sub ? ({1'b0, mx} - {1'b0, my_sh})
            : ({1'b0, mx} + {1'b0, my_sh});
    e     = {2'b00, ex};
    lz    = 5'd0;
    sh    = 5'd0;
    found = 1'b0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && s[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      if (!found) lz = 5'd26;
      sh = ({5'd0, lz} >= e) ? 5'(e - 10'd1) : lz;
      s  = s << sh;
      e  = e - {5'd0, sh};
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    mr = {1'b0, s[26:3]} + {24'd0, up};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]};
      e  = e + 10'd1;
    end
    Exception = 1'b0;
    if (x[30:23] == 8'hFF) begin
      Exception = 1'b1;
      result    = (sub && y[30:23] == 8'hFF) ? 32'h7FC0_0000 : x;
    end else if (e >= 10'd255) begin
      Exception = 1'b1;
      result    = {sx, 8'hFF, 23'd0};
    end else if (mr[23:0] == 24'd0) begin
      result = {sx & ~sub, 31'd0};
    end else begin
      result = {sx, mr[23] ? e[7:0] : 8'd0, mr[22:0]};
    end
  end

endmodule

// File: rtl/neuron_input_accumulator.sv
// Per-neuron spike accumulator: weight lookup, float32 sum per
// timestep, result handed to the potential adder via valid/ack.
module neuron_input_accumulator
  import neuron_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int SRC_W   = 4
) (
  input logic clk,
  input logic rst_n,
  neuron_input_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [FP_W-1:0]  w_q, w_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [FP_W-1:0]  iw_q, iw_d;
  logic [FP_W-1:0]  sum;
  logic             ts_pend_q, ts_pend_d;
  logic             wvld_q, wvld_d;
  logic             ovr_q, ovr_d;
  logic             exc_q, exc_d;
  logic [FP_W-1:0]  wt_q [NUM_SRC];
  logic [FP_W-1:0]  wt_d [NUM_SRC];
  logic             add_exc, ready, accept;

  Addition_Subtraction u_fpadd (
    .a_operand  (acc_q),
    .b_operand  (w_q),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (sum)
  );

  assign ready  = (state_q == IDLE) && !bus.time_step && !ts_pend_q;
  assign accept = bus.spike_valid && ready;

  assign bus.spike_ready  = ready;
  assign bus.input_weight = iw_q;
  assign bus.weight_valid = wvld_q;
  assign bus.overrun      = ovr_q;
  assign bus.fp_exc       = exc_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    w_d       = w_q;
    acc_d     = acc_q;
    iw_d      = iw_q;
    ts_pend_d = ts_pend_q;
    wvld_d    = wvld_q;
    ovr_d     = ovr_q;
    exc_d     = exc_q;
    wt_d      = wt_q;
    if (bus.weight_wr_en) wt_d[bus.weight_wr_addr] = bus.weight_wr_data;
    unique case (state_q)
      IDLE: begin
        if (bus.time_step) begin
          state_d = FLUSH;
          iw_d    = acc_q;
          wvld_d  = 1'b1;
          acc_d   = FP_ZERO;
        end else if (accept) begin
          src_d   = bus.spike_src;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        w_d     = wt_q[src_q];
        state_d = ADD;
        if (bus.time_step) ts_pend_d = 1'b1;
      end
      ADD: begin
        if (add_exc) exc_d = 1'b1;
        // The in-flight spike belongs to the timestep being closed
        if (ts_pend_q || bus.time_step) begin
          ts_pend_d = 1'b0;
          state_d   = FLUSH;
          iw_d      = sum;
          wvld_d    = 1'b1;
          acc_d     = FP_ZERO;
        end else begin
          acc_d   = sum;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (bus.time_step) ovr_d = 1'b1;
        if (bus.weight_ack) begin
          wvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      w_q       <= FP_ZERO;
      acc_q     <= FP_ZERO;
      iw_q      <= FP_ZERO;
      ts_pend_q <= 1'b0;
      wvld_q    <= 1'b0;
      ovr_q     <= 1'b0;
      exc_q     <= 1'b0;
      wt_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      w_q       <= w_d;
      acc_q     <= acc_d;
      iw_q      <= iw_d;
      ts_pend_q <= ts_pend_d;
      wvld_q    <= wvld_d;
      ovr_q     <= ovr_d;
      exc_q     <= exc_d;
      wt_q      <= wt_d;
    end
  end

endmodule

// File: tb/tb_neuron_input_accumulator.sv
// Directed bench for neuron_input_accumulator with hand-computed
// float32 sums, handshake timing and sticky flag checks.
module tb_neuron_input_accumulator;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  neuron_input_accumulator_if #(.SRC_W(4)) bus ();

  neuron_input_accumulator #(
    .NUM_SRC (16),
    .SRC_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    bus.weight_wr_en   = 1'b1;
    bus.weight_wr_addr = a;
    bus.weight_wr_data = v;
    step();
    bus.weight_wr_en   = 1'b0;
  endtask

  task automatic send(input logic [3:0] src);
    bus.spike_valid = 1'b1;
    bus.spike_src   = src;
    #1;
    chk("ready_offer", 32'(bus.spike_ready), 32'd1);
    step();
    bus.spike_valid = 1'b0;
    chk("ready_lookup", 32'(bus.spike_ready), 32'd0);
    step();
    chk("ready_add", 32'(bus.spike_ready), 32'd0);
    step();
    chk("ready_back", 32'(bus.spike_ready), 32'd1);
  endtask

  task automatic flush(input string tag, input logic [31:0] exp);
    bus.time_step = 1'b1;
    step();
    bus.time_step = 1'b0;
    chk({tag, "_valid"}, 32'(bus.weight_valid), 32'd1);
    chk({tag, "_sum"}, bus.input_weight, exp);
    bus.weight_ack = 1'b1;
    step();
    bus.weight_ack = 1'b0;
    chk({tag, "_ackd"}, 32'(bus.weight_valid), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    bus.weight_wr_en = 1'b0;
    bus.weight_wr_addr = '0;
    bus.weight_wr_data = '0;
    bus.spike_valid = 1'b0;
    bus.spike_src = '0;
    bus.time_step = 1'b0;
    bus.weight_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.weight_valid), 32'd0);
    chk("rst_sum", bus.input_weight, 32'h0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_exc", 32'(bus.fp_exc), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.spike_ready), 32'd1);

    // 1.0 + 2.5
    wr(4'd0, 32'h3F80_0000);
    wr(4'd1, 32'h4020_0000);
    send(4'd0);
    send(4'd1);
    flush("t1", 32'h4060_0000);
    chk("t1_idle", 32'(bus.spike_ready), 32'd1);

    // empty timestep, also shows acc was cleared
    flush("t2", 32'h0000_0000);

    // 0.5 - 1.0 + 0.5 = +0
    wr(4'd2, 32'h3F00_0000);
    wr(4'd3, 32'hBF80_0000);
    send(4'd2);
    send(4'd3);
    send(4'd2);
    flush("t3", 32'h0000_0000);

    // time_step during ADD of a src-0 spike
    bus.spike_valid = 1'b1;
    bus.spike_src = 4'd0;
    step();
    bus.spike_valid = 1'b0;
    step();
    bus.time_step = 1'b1;
    step();
    bus.time_step = 1'b0;
    chk("t4_valid", 32'(bus.weight_valid), 32'd1);
    chk("t4_sum", bus.input_weight, 32'h3F80_0000);
    bus.weight_ack = 1'b1;
    step();
    bus.weight_ack = 1'b0;

    // coincident spike and time_step in IDLE: timestep wins
    bus.spike_valid = 1'b1;
    bus.spike_src = 4'd1;
    bus.time_step = 1'b1;
    #1;
    chk("t4_coin_ready", 32'(bus.spike_ready), 32'd0);
    step();
    bus.spike_valid = 1'b0;
    bus.time_step = 1'b0;
    chk("t4_coin_valid", 32'(bus.weight_valid), 32'd1);
    chk("t4_coin_sum", bus.input_weight, 32'h0);
    bus.weight_ack = 1'b1;
    step();
    bus.weight_ack = 1'b0;

    // write during LOOKUP of the same entry reads the old value
    wr(4'd5, 32'h3F80_0000);
    bus.spike_valid = 1'b1;
    bus.spike_src = 4'd5;
    step();
    bus.spike_valid = 1'b0;
    bus.weight_wr_en = 1'b1;
    bus.weight_wr_addr = 4'd5;
    bus.weight_wr_data = 32'h4020_0000;
    step();
    bus.weight_wr_en = 1'b0;
    step();
    flush("t5_old", 32'h3F80_0000);
    send(4'd5);
    flush("t5_new", 32'h4020_0000);

    // overrun with ack held low
    send(4'd0);
    bus.time_step = 1'b1;
    step();
    bus.time_step = 1'b0;
    chk("ovr_valid", 32'(bus.weight_valid), 32'd1);
    step();
    bus.time_step = 1'b1;
    step();
    bus.time_step = 1'b0;
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    chk("ovr_valid2", 32'(bus.weight_valid), 32'd1);
    chk("ovr_sum", bus.input_weight, 32'h3F80_0000);
    chk("ovr_noready", 32'(bus.spike_ready), 32'd0);
    bus.weight_ack = 1'b1;
    step();
    bus.weight_ack = 1'b0;
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // reset mid-LOOKUP
    send(4'd1);
    bus.spike_valid = 1'b1;
    bus.spike_src = 4'd1;
    step();
    bus.spike_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovr", 32'(bus.overrun), 32'd0);
    chk("mid_rst_valid", 32'(bus.weight_valid), 32'd0);
    chk("mid_rst_sum", bus.input_weight, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.spike_ready), 32'd1);
    send(4'd1);
    flush("wt_lost", 32'h0000_0000);

    // max float twice overflows to +Inf
    wr(4'd6, 32'h7F7F_FFFF);
    send(4'd6);
    chk("exc_clear", 32'(bus.fp_exc), 32'd0);
    send(4'd6);
    chk("exc_set", 32'(bus.fp_exc), 32'd1);
    flush("exc_ts", 32'h7F80_0000);
    flush("exc_next", 32'h0000_0000);
    chk("exc_sticky", 32'(bus.fp_exc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_input_accumulator.md
# neuron_input_accumulator

Collects incoming spike events for one neuron during a timestep, looks up each source's synaptic weight, and accumulates the weights as IEEE-754 single-precision. On each timestep boundary it presents the accumulated total as `input_weight` to the neuron's potential adder through a valid/ack handshake, then clears for the next timestep. It sits between the NoC spike-delivery port and the neuron's potential-update stage.

## Interface
- `NUM_SRC`, default 16: number of presynaptic sources (weight entries).
- `SRC_W`, default 4: source-id width, equal to clog2(`NUM_SRC`).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `weight_wr_en`  in  1: write a weight entry this cycle.
- `weight_wr_addr`  in  SRC_W: entry to write.
- `weight_wr_data`  in  32: float32 weight.
- `spike_valid`  in  1: a spike event is offered.
- `spike_src`  in  SRC_W: source id of the offered spike.
- `spike_ready`  out  1: the accumulator accepts the spike this cycle.
- `time_step`  in  1: single-cycle timestep-boundary pulse.
- `input_weight`  out  32: accumulated float32 sum for the finished timestep.
- `weight_valid`  out  1: `input_weight` is valid; held until acknowledged.
- `weight_ack`  in  1: the potential adder consumed `input_weight`.
- `overrun`  out  1: sticky flag; a `time_step` arrived while the previous result was still unacknowledged.
- `fp_exc`  out  1: sticky flag; the float adder raised an exception.

## Operation
- The state machine has four states: IDLE, LOOKUP, ADD, FLUSH.
- `spike_ready` = (state==IDLE) && !`time_step` && !`ts_pending`.
- IDLE:
  - A spike handshake latches `spike_src` and moves to LOOKUP.
  - A `time_step` pulse moves to FLUSH.
  - When `time_step` and `spike_valid` coincide, the timestep wins and the spike is not accepted.
- LOOKUP: register `w = weights[src]`, then move to ADD.
- ADD: `acc <= acc + w` via the float adder (add mode). Then:
  - If `ts_pending` is set, clear it and go to FLUSH.
  - Otherwise return to IDLE.
- A `time_step` arriving in LOOKUP or ADD sets `ts_pending`. The in-flight spike completes and is counted in the current timestep.
- FLUSH entry:
  - `input_weight <= acc` (the sum including any ADD completing that cycle).
  - `weight_valid <= 1`.
  - `acc <= +0.0` (32'h00000000).
- FLUSH hold: stay until `weight_ack`. On ack, deassert `weight_valid` and return to IDLE.
- A `time_step` pulse during FLUSH sets `overrun`. That timestep is dropped, not queued. Spikes are not accepted during FLUSH.
- A timestep with no spikes still produces a handshake with `input_weight` = 32'h00000000.
- Weight writes:
  - Accepted in any state, one entry per cycle.
  - A write to the entry being read in LOOKUP in the same cycle returns the old value.
- Accumulation:
  - Uses float32 only, with no saturation.
  - If the adder's exception output is high on an ADD cycle, set `fp_exc`; the adder result is still stored.
- `overrun` and `fp_exc` clear only on reset.

## Timing
- Reset values:
  - state IDLE, `acc` 0, `ts_pending` 0.
  - All weight entries 32'h00000000.
  - `input_weight` 0, `weight_valid` 0, `overrun` 0, `fp_exc` 0.
  - `spike_ready` 1 once reset is released.
- Per-spike occupancy is 3 cycles (accept, LOOKUP, ADD). Peak throughput is one spike per 3 cycles.
- `weight_valid` rises 1 cycle after a `time_step` seen in IDLE. If a spike was in flight, it rises 1 cycle after that spike's ADD.
- `weight_ack` may arrive in the same cycle `weight_valid` rises. IDLE is re-entered the next cycle.
- Reset mid-operation:
  - An asynchronous assertion clears everything immediately.
  - A partially accumulated sum is discarded.
  - Configured weights are also lost.

## Structure
- Shared package `neuron_pkg`:
  - `FP_W` = 32, `FP_ZERO` = 32'h00000000.
  - The `acc_state_t` enum (IDLE, LOOKUP, ADD, FLUSH).
- Sub-module: one instance of the team's existing `Addition_Subtraction` float adder, with its operation input tied to add.
- The weight store is a register array of `NUM_SRC` × 32 bits; no RAM macro.

## Test plan
- Weights [0]=3F800000 (1.0) and [1]=40200000 (2.5); spikes from src 0 and src 1; then `time_step` → `weight_valid` with `input_weight`=40600000 (3.5); ack returns to IDLE and `acc` reads 0.
- `time_step` with no spikes → `input_weight`=00000000 and one valid/ack handshake.
- Weights [2]=3F000000 (0.5) and [3]=BF800000 (-1.0); spikes 2, 3, 2 → `input_weight`=00000000; the spike stream shows `spike_ready` low for 2 cycles after each accept.
- `time_step` pulsed during the ADD of a src-0 spike (weight 1.0) → `weight_valid` the cycle after ADD, `input_weight`=3F800000; a coincident `spike_valid` in IDLE with `time_step` is not accepted.
- `weight_ack` held low, second `time_step` → `overrun`=1, `input_weight` unchanged; `rst_n` pulsed low mid-LOOKUP → all outputs and weights zero immediately.
- Weight 7F7FFFFF (max float) summed twice → `fp_exc`=1 and sticky across the next timestep.
